boot_monitor: RTL and testbench
===============================

Name: boot_monitor

Overview:
- Serial boot/debug monitor sitting directly upstream of the CPU core.
- Receives byte commands from the UART receiver and loads or inspects the byte-wide program RAM through the same memory port style the CPU uses.
- Drives the CPU's reset, halt and start_address inputs; owns RAM whenever the CPU is held in reset.

Parameters:
addr_width, 9, RAM address bits; must match the CPU's addr_width.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx_data  input  8  received UART byte
rx_valid  input  1  one-cycle strobe, rx_data valid
tx_data  output  8  byte to UART transmitter
tx_valid  output  1  tx_data valid; held until accepted
tx_ready  input  1  transmitter accepts tx_data when high with tx_valid
mem_data_out  input  8  RAM read data
mem_data_in  output  8  RAM write data
mem_raddr  output  addr_width  RAM read address
mem_waddr  output  addr_width  RAM write address
mem_write  output  1  RAM write strobe, one cycle per byte
mem_owner  output  1  1 = monitor drives RAM mux (equals cpu_reset)
cpu_reset  output  1  active-high synchronous reset to CPU
cpu_halt  output  1  halt request to CPU
cpu_halted  input  1  CPU halted status
start_address  output  addr_width  CPU start address
overrun  output  1  sticky: rx byte dropped

Behaviour:
- Reset (reset=0, async) values: cpu_reset=1, cpu_halt=0, start_address=0, mem_write=0, mem_raddr=mem_waddr=0, mem_data_in=0, tx_valid=0, tx_data=0, overrun=0; state IDLE. Asserting reset mid-command aborts the command; no partial reply is sent.
- Argument framing: multi-byte arguments are big-endian 16-bit values. Addresses are truncated to addr_width. Length is 16-bit; length 0 means no data bytes.
- Commands, first byte in IDLE:
  - 'W' 0x57 + addr(2) + len(2) + len data bytes:
    - Each data byte is written at addr: the cycle after its rx_valid, mem_waddr=addr, mem_data_in=byte, mem_write=1 for exactly 1 cycle.
    - addr increments mod 2^addr_width after each byte.
    - Reply 'K' 0x4B after the last byte, or immediately after the args when len=0.
  - 'R' 0x52 + addr(2) + len(2):
    - Per byte: set mem_raddr, wait 2 cycles (RAM latency), capture mem_data_out, then transmit it.
    - Wait for tx accept before the next address. addr wraps as for W.
    - No trailing 'K'. len=0 sends nothing.
  - 'G' 0x47 + addr(2):
    - start_address<=addr; cpu_halt<=0; cpu_reset held 1 for 2 further cycles, then 0.
    - Reply 'K' after release.
  - 'H' 0x48:
    - cpu_halt<=1 and stays 1 until the next G.
    - Wait for cpu_halted=1, then reply 'K'. If cpu_reset=1, reply 'K' at once.
  - Any other byte: reply '?' 0x3F.
- Busy rule: W/R/G while cpu_reset=0 and cpu_halted=0 ("running"):
  - All argument and data bytes are still consumed; no RAM write or read occurs.
  - Reply 'B' 0x42 after the final byte.
  - G while halted (cpu_reset=0, cpu_halted=1) is allowed and restarts the CPU.
- RAM access when CPU is halted but not in reset: W and R are allowed. mem_owner stays 0 here; top level must gate on cpu_halted.
- TX handshake:
  - tx_valid rises with tx_data stable and drops the cycle after tx_ready=1 is sampled.
  - tx_data/tx_valid never change while tx_valid=1 and tx_ready=0.
- States: IDLE, ARG, WDATA, RADDR, RWAIT1, RWAIT2, RTX, GOPULSE, HALTWAIT, REPLY.
- Dropped input: rx_valid in RADDR/RWAIT*/RTX/GOPULSE/HALTWAIT/REPLY drops the byte and sets overrun=1. overrun clears only on reset.
- rx_valid in the same cycle tx is accepted in REPLY is dropped (overrun=1); the next command begins in IDLE.
- mem_write is never asserted except in WDATA with the CPU not running.

Test Plan:
- Reset release → cpu_reset=1, mem_owner=1, start_address=0, tx_valid=0, overrun=0.
- Rx 57 00 10 00 03 AA BB CC → mem_write pulses at 0x010/0x011/0x012 with AA/BB/CC; then tx 4B.
- After that load, rx 52 00 10 00 03 with tx_ready stalled 5 cycles per byte → tx AA, BB, CC in order, each held stable through the stall.
- Rx 57 01 FF 00 02 11 22 (addr_width=9) → writes at 0x1FF then 0x000; then rx 47 00 10 → start_address=0x010, cpu_reset low after 2 cycles, tx 4B.
- CPU running: rx 57 00 00 00 01 55 → no mem_write, tx 42. Then rx 48, cpu_halted asserted 10 cycles later → cpu_halt=1, tx 4B only after cpu_halted.
- Rx 5A → tx 3F. Rx byte during R streaming → overrun=1. Async reset mid-W → outputs return to reset values immediately and no reply is sent.

Source files
------------

// File: rtl/boot_monitor_if.sv
// boot_monitor_if: UART byte stream plus program-RAM port shared by boot_monitor and its surroundings.
interface boot_monitor_if #(parameter int addr_width = 9);
  logic [7:0] rx_data;
  logic rx_valid;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [7:0] mem_data_out;
  logic [7:0] mem_data_in;
  logic [addr_width-1:0] mem_raddr;
  logic [addr_width-1:0] mem_waddr;
  logic mem_write;
  modport master (
    input rx_data, rx_valid, tx_ready, mem_data_out,
    output tx_data, tx_valid, mem_data_in, mem_raddr, mem_waddr, mem_write
  );
  modport slave (
    output rx_data, rx_valid, tx_ready, mem_data_out,
    input tx_data, tx_valid, mem_data_in, mem_raddr, mem_waddr, mem_write
  );
endinterface

// File: rtl/boot_monitor.sv
// boot_monitor: serial command monitor that loads/dumps program RAM and drives CPU reset, halt and start address.
module boot_monitor #(parameter int addr_width = 9) (
  input  logic clk,
  input  logic reset,
  boot_monitor_if.master bus,
  output logic mem_owner,
  output logic cpu_reset,
  output logic cpu_halt,
  input  logic cpu_halted,
  output logic [addr_width-1:0] start_address,
  output logic overrun
);
  typedef enum logic [3:0] {IDLE, ARG, WDATA, RADDR, RWAIT1, RWAIT2, RTX, GOPULSE, HALTWAIT, REPLY} state_t;
  localparam logic [7:0] C_W = 8'h57, C_R = 8'h52, C_G = 8'h47, C_H = 8'h48;
  state_t state, state_n;
  logic [7:0] cmd, cmd_n, tx_data_q, tx_data_n, mem_data_in_q, mem_data_in_n, reply_byte;
  logic [1:0] argc, argc_n;
  logic [addr_width-1:0] addr, addr_n, addr_sh, mem_raddr_q, mem_raddr_n, mem_waddr_q, mem_waddr_n, start_n;
  logic [15:0] len, len_n, len_sh;
  logic busy, busy_n, go, go_n, tx_valid_q, tx_valid_n, mem_write_q, mem_write_n;
  logic cpu_reset_n, cpu_halt_n, overrun_n, reply_en, last_arg;
  assign bus.tx_data = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.mem_data_in = mem_data_in_q;
  assign bus.mem_raddr = mem_raddr_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_write = mem_write_q;
  assign mem_owner = cpu_reset;
  assign addr_sh = addr_width'({addr, bus.rx_data});
  assign len_sh = {len[7:0], bus.rx_data};
  assign last_arg = argc == ((cmd == C_G) ? 2'd1 : 2'd3);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cmd <= '0;
      argc <= '0;
      addr <= '0;
      len <= '0;
      busy <= 1'b0;
      go <= 1'b0;
      tx_data_q <= '0;
      tx_valid_q <= 1'b0;
      mem_data_in_q <= '0;
      mem_raddr_q <= '0;
      mem_waddr_q <= '0;
      mem_write_q <= 1'b0;
      cpu_reset <= 1'b1;
      cpu_halt <= 1'b0;
      start_address <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      cmd <= cmd_n;
      argc <= argc_n;
      addr <= addr_n;
      len <= len_n;
      busy <= busy_n;
      go <= go_n;
      tx_data_q <= tx_data_n;
      tx_valid_q <= tx_valid_n;
      mem_data_in_q <= mem_data_in_n;
      mem_raddr_q <= mem_raddr_n;
      mem_waddr_q <= mem_waddr_n;
      mem_write_q <= mem_write_n;
      cpu_reset <= cpu_reset_n;
      cpu_halt <= cpu_halt_n;
      start_address <= start_n;
      overrun <= overrun_n;
    end
  always_comb begin
    state_n = state;
    cmd_n = cmd;
    argc_n = argc;
    addr_n = addr;
    len_n = len;
    busy_n = busy;
    go_n = go;
    tx_data_n = tx_data_q;
    tx_valid_n = tx_valid_q;
    mem_data_in_n = mem_data_in_q;
    mem_raddr_n = mem_raddr_q;
    mem_waddr_n = mem_waddr_q;
    mem_write_n = 1'b0;
    cpu_reset_n = cpu_reset;
    cpu_halt_n = cpu_halt;
    start_n = start_address;
    overrun_n = overrun | (bus.rx_valid && !(state inside {IDLE, ARG, WDATA}));
    reply_en = 1'b0;
    reply_byte = 8'h4B;
    case (state)
      IDLE: if (bus.rx_valid) begin
        cmd_n = bus.rx_data;
        argc_n = '0;
        addr_n = '0;
        busy_n = !cpu_reset && !cpu_halted;
        if (bus.rx_data inside {C_W, C_R, C_G}) state_n = ARG;
        else if (bus.rx_data == C_H) begin
          cpu_halt_n = 1'b1;
          reply_en = cpu_reset;
          state_n = cpu_reset ? REPLY : HALTWAIT;
        end else begin
          reply_en = 1'b1;
          reply_byte = 8'h3F;
        end
      end
      ARG: if (bus.rx_valid) begin
        argc_n = argc + 2'd1;
        if (argc < 2'd2) addr_n = addr_sh;
        else len_n = len_sh;
        if (last_arg) begin
          // A busy command still consumes its bytes but always answers 'B'.
          reply_byte = busy ? 8'h42 : 8'h4B;
          if (cmd == C_G) begin
            reply_en = busy;
            if (!busy) begin
              start_n = addr_sh;
              cpu_halt_n = 1'b0;
              cpu_reset_n = 1'b1;
              go_n = 1'b0;
              state_n = GOPULSE;
            end
          end else if (cmd == C_W) begin
            reply_en = len_sh == 16'd0;
            state_n = WDATA;
          end else begin
            reply_en = busy;
            state_n = (len_sh == 16'd0) ? IDLE : RADDR;
          end
        end
      end
      WDATA: if (bus.rx_valid) begin
        mem_write_n = !busy;
        mem_waddr_n = busy ? mem_waddr_q : addr;
        mem_data_in_n = busy ? mem_data_in_q : bus.rx_data;
        addr_n = addr + 1'b1;
        len_n = len - 16'd1;
        reply_en = len == 16'd1;
        reply_byte = busy ? 8'h42 : 8'h4B;
      end
      RADDR: begin
        mem_raddr_n = addr;
        state_n = RWAIT1;
      end
      RWAIT1: state_n = RWAIT2;
      RWAIT2: begin
        tx_data_n = bus.mem_data_out;
        tx_valid_n = 1'b1;
        state_n = RTX;
      end
      RTX: if (bus.tx_ready) begin
        tx_valid_n = 1'b0;
        addr_n = addr + 1'b1;
        len_n = len - 16'd1;
        state_n = (len == 16'd1) ? IDLE : RADDR;
      end
      GOPULSE: begin
        go_n = 1'b1;
        cpu_reset_n = !go;
        reply_en = go;
      end
      HALTWAIT: reply_en = cpu_halted;
      REPLY: if (bus.tx_ready) begin
        tx_valid_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (reply_en) begin
      tx_data_n = reply_byte;
      tx_valid_n = 1'b1;
      state_n = REPLY;
    end
  end
endmodule

// File: tb/tb_boot_monitor.sv
// tb_boot_monitor: directed command sequences against boot_monitor with a one-cycle RAM model.
module tb_boot_monitor;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mem_owner, cpu_reset, cpu_halt, overrun;
  logic cpu_halted = 1'b0;
  logic [8:0] start_address;
  logic [7:0] ram [0:511];
  int total = 0, bad = 0;
  int wlog[$];
  boot_monitor_if #(.addr_width(9)) bus();
  boot_monitor #(.addr_width(9)) dut (
    .clk(clk), .reset(reset), .bus(bus.master), .mem_owner(mem_owner),
    .cpu_reset(cpu_reset), .cpu_halt(cpu_halt), .cpu_halted(cpu_halted),
    .start_address(start_address), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_write) ram[bus.mem_waddr] <= bus.mem_data_in;
    bus.mem_data_out <= ram[bus.mem_raddr];
  end
  always @(negedge clk) if (bus.mem_write) wlog.push_back({bus.mem_waddr, bus.mem_data_in});
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask
  task automatic send_n(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) send(v[8*(n-1-i) +: 8]);
  endtask
  task automatic get_tx(input string tag, input logic [7:0] exp, input int stall);
    int n = 0;
    logic [7:0] held;
    logic ok = 1'b1;
    while (!bus.tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_valid) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    held = bus.tx_data;
    repeat (stall) begin
      @(negedge clk);
      if (!bus.tx_valid || bus.tx_data != held) ok = 1'b0;
    end
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    chk(tag, held, exp);
    if (stall > 0) chk({tag, "_hold"}, ok, 1);
    chk({tag, "_drop"}, bus.tx_valid, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal;
  end
  initial begin
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_owner", mem_owner, 1);
    chk("rst_start", start_address, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_halt", cpu_halt, 0);
    send_n(64'h57_00_10_00_03_AA_BB_CC, 8);
    get_tx("w1_k", 8'h4B, 0);
    chk("w1_cnt", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("w1_0", wlog[0], 'h010AA);
      chk("w1_1", wlog[1], 'h011BB);
      chk("w1_2", wlog[2], 'h012CC);
    end
    wlog.delete();
    send_n(64'h57_00_00_00_00, 5);
    get_tx("w0_k", 8'h4B, 0);
    chk("w0_cnt", wlog.size(), 0);
    send_n(64'h52_00_10_00_03, 5);
    get_tx("r_aa", 8'hAA, 5);
    get_tx("r_bb", 8'hBB, 5);
    get_tx("r_cc", 8'hCC, 5);
    repeat (10) @(negedge clk);
    chk("r_no_k", bus.tx_valid, 0);
    send_n(64'h57_01_FF_00_02_11_22, 7);
    get_tx("w2_k", 8'h4B, 0);
    chk("w2_cnt", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("w2_0", wlog[0], 'h1FF11);
      chk("w2_1", wlog[1], 'h00022);
    end
    wlog.delete();
    send_n(64'h47_00_10, 3);
    chk("g_start", start_address, 'h010);
    chk("g_rst_hold1", cpu_reset, 1);
    @(negedge clk);
    chk("g_rst_hold2", cpu_reset, 1);
    @(negedge clk);
    chk("g_rst_rel", cpu_reset, 0);
    chk("g_owner", mem_owner, 0);
    get_tx("g_k", 8'h4B, 0);
    send_n(64'h57_00_00_00_01_55, 6);
    get_tx("busy_b", 8'h42, 0);
    chk("busy_nowrite", wlog.size(), 0);
    send(8'h48);
    chk("h_halt", cpu_halt, 1);
    repeat (10) @(negedge clk);
    chk("h_wait", bus.tx_valid, 0);
    cpu_halted = 1'b1;
    get_tx("h_k", 8'h4B, 0);
    send(8'h5A);
    get_tx("bad_cmd", 8'h3F, 0);
    chk("ovr_pre", overrun, 0);
    send_n(64'h52_00_10_00_01, 5);
    send(8'h00);
    chk("ovr_set", overrun, 1);
    get_tx("ovr_r", 8'hAA, 0);
    wlog.delete();
    send_n(64'h57_00_20_00_02_77, 6);
    #2 reset = 1'b0;
    #1;
    chk("ar_cpu_reset", cpu_reset, 1);
    chk("ar_halt", cpu_halt, 0);
    chk("ar_overrun", overrun, 0);
    chk("ar_start", start_address, 0);
    chk("ar_tx_valid", bus.tx_valid, 0);
    chk("ar_raddr", bus.mem_raddr, 0);
    chk("ar_wcnt", wlog.size(), 1);
    cpu_halted = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("ar_no_reply", bus.tx_valid, 0);
    send(8'h5A);
    get_tx("ar_idle", 8'h3F, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
